// File: rtl/pixel_stream_receiver_pkg.sv
// Shared configuration and types for the pixel stream receive path.
// Both the receiver RTL and its bench import these constants and types.
package pixel_stream_receiver_pkg;

   localparam int RX_PIXEL_BITS    = 8;
   localparam int RX_BUS_WIDTH     = 4;
   localparam int RX_ARRAY_WIDTH   = 128;
   localparam int RX_ARRAY_HEIGHT  = 128;
   localparam int RX_SUM_BITS      = 24;
   localparam int RX_BEATS_PER_ROW = RX_ARRAY_WIDTH / RX_BUS_WIDTH;
   localparam int RX_TOTAL_BEATS   = RX_BEATS_PER_ROW * RX_ARRAY_HEIGHT;

   typedef logic [RX_BUS_WIDTH-1:0][RX_PIXEL_BITS-1:0] beat_t;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      WAIT_END,
      DONE
   } rx_state_t;

   typedef enum logic [1:0] {
      OK      = 2'b00,
      SHORT   = 2'b01,
      OVERRUN = 2'b10
   } rx_err_t;

endpackage

// File: rtl/sync_falling_edge.sv
// Two-flop synchroniser with a history flop; flags a falling edge of an
// asynchronous level. Flops reset high, so a low input after reset reads as a fall.
module sync_falling_edge (
   input  logic output_clk,
   input  logic reset,
   input  logic i_async,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge output_clk) begin
      if (!reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/pixel_stream_receiver.sv
// Receive-side sink for the sensor output bus: writes each beat to a frame
// buffer port, tracks row/column position and reports frame status.
module pixel_stream_receiver
   import pixel_stream_receiver_pkg::*;
#(
   parameter int PIXEL_BITS   = RX_PIXEL_BITS,
   parameter int BUS_WIDTH    = RX_BUS_WIDTH,
   parameter int ARRAY_WIDTH  = RX_ARRAY_WIDTH,
   parameter int ARRAY_HEIGHT = RX_ARRAY_HEIGHT,
   parameter int SUM_BITS     = RX_SUM_BITS
) (
   input  logic                                                output_clk,
   input  logic                                                reset,
   input  logic                                                arm,
   input  logic [BUS_WIDTH*PIXEL_BITS-1:0]                     data_in,
   input  logic                                                data_valid,
   input  logic                                                frame_finished,
   output logic                                                mem_we,
   output logic [$clog2(ARRAY_WIDTH*ARRAY_HEIGHT/BUS_WIDTH)-1:0] mem_addr,
   output logic [BUS_WIDTH*PIXEL_BITS-1:0]                     mem_wdata,
   output logic                                                row_done,
   output logic                                                frame_done,
   output logic [1:0]                                          frame_error,
   output logic [SUM_BITS-1:0]                                 pixel_sum,
   output logic                                                busy
);

   localparam int BPR    = ARRAY_WIDTH / BUS_WIDTH;
   localparam int TOTAL  = BPR * ARRAY_HEIGHT;
   localparam int ADDR_W = $clog2(TOTAL);
   localparam int COL_W  = (BPR > 1) ? $clog2(BPR) : 1;
   localparam int ROW_W  = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;

   rx_state_t r_state;
   rx_state_t w_nextState;
   rx_err_t   r_error;

   logic [COL_W-1:0]                r_col;
   logic [ROW_W-1:0]                r_row;
   logic [ADDR_W-1:0]               r_beat;
   logic [ADDR_W-1:0]               r_memAddr;
   logic [BUS_WIDTH*PIXEL_BITS-1:0] r_memWdata;
   logic [SUM_BITS-1:0]             r_pixelSum;
   logic                            r_memWe;
   logic                            r_rowDone;
   logic                            r_frameDone;

   logic                w_fall;
   logic                w_colWrap;
   logic                w_lastBeat;
   logic                w_start;
   logic                w_accept;
   logic                w_short;
   logic                w_overrun;
   logic                w_donePulse;
   logic [SUM_BITS-1:0] w_beatSum;

   sync_falling_edge u_frameSync (
      .output_clk (output_clk),
      .reset      (reset),
      .i_async    (frame_finished),
      .o_fall     (w_fall)
   );

   assign w_colWrap  = (r_col == COL_W'(BPR - 1));
   assign w_lastBeat = w_colWrap && (r_row == ROW_W'(ARRAY_HEIGHT - 1));

   always_comb begin
      w_beatSum = '0;
      for (int i = 0; i < BUS_WIDTH; i++) begin
         w_beatSum = w_beatSum + SUM_BITS'(data_in[i*PIXEL_BITS +: PIXEL_BITS]);
      end
   end

   always_ff @(posedge output_clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A fall that lands on the final beat counts as a clean frame end.
   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      w_accept    = 1'b0;
      w_short     = 1'b0;
      w_overrun   = 1'b0;
      w_donePulse = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (arm) begin
               w_start     = 1'b1;
               w_nextState = CAPTURE;
            end
         end
         CAPTURE: begin
            w_accept = data_valid;
            if (data_valid && w_lastBeat) begin
               w_nextState = w_fall ? DONE : WAIT_END;
            end else if (w_fall) begin
               w_short     = 1'b1;
               w_nextState = IDLE;
            end
         end
         WAIT_END: begin
            w_overrun = data_valid;
            if (w_fall) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_donePulse = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge output_clk) begin
      if (!reset) begin
         r_col       <= '0;
         r_row       <= '0;
         r_beat      <= '0;
         r_memAddr   <= '0;
         r_memWdata  <= '0;
         r_pixelSum  <= '0;
         r_memWe     <= 1'b0;
         r_rowDone   <= 1'b0;
         r_frameDone <= 1'b0;
         r_error     <= OK;
      end else begin
         r_memWe     <= w_accept;
         r_rowDone   <= w_accept && w_colWrap;
         r_frameDone <= w_short || w_donePulse;
         if (w_start) begin
            r_col      <= '0;
            r_row      <= '0;
            r_beat     <= '0;
            r_pixelSum <= '0;
            r_error    <= OK;
         end
         if (w_accept) begin
            r_memAddr  <= r_beat;
            r_memWdata <= data_in;
            r_pixelSum <= r_pixelSum + w_beatSum;
            r_beat     <= r_beat + 1'b1;
            if (w_colWrap) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (w_short) begin
            r_error <= SHORT;
         end
         if (w_overrun) begin
            r_error <= OVERRUN;
         end
      end
   end

   assign mem_we      = r_memWe;
   assign mem_addr    = r_memAddr;
   assign mem_wdata   = r_memWdata;
   assign row_done    = r_rowDone;
   assign frame_done  = r_frameDone;
   assign frame_error = r_error;
   assign pixel_sum   = r_pixelSum;
   assign busy        = (r_state == CAPTURE) || (r_state == WAIT_END);

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Self-checking bench for pixel_stream_receiver: drives whole and partial frames
// and compares writes, row/frame pulses, status and checksum against a frame model.
module tb_pixel_stream_receiver;
   import pixel_stream_receiver_pkg::*;

   localparam int PB     = RX_PIXEL_BITS;
   localparam int BW     = RX_BUS_WIDTH;
   localparam int SB     = RX_SUM_BITS;
   localparam int BPR    = RX_BEATS_PER_ROW;
   localparam int TOTAL  = RX_TOTAL_BEATS;
   localparam int ADDR_W = $clog2(TOTAL);

   logic              output_clk = 1'b0;
   logic              reset = 1'b0;
   logic              arm = 1'b0;
   logic [BW*PB-1:0]  data_in = '0;
   logic              data_valid = 1'b0;
   logic              frame_finished = 1'b1;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [BW*PB-1:0]  mem_wdata;
   logic              row_done;
   logic              frame_done;
   logic [1:0]        frame_error;
   logic [SB-1:0]     pixel_sum;
   logic              busy;

   int checks = 0;
   int errors = 0;

   int cycle = 0;
   int doneCount = 0;
   int lastWeCycle = -1;
   int lastDoneCycle = -1;
   logic [ADDR_W-1:0] wrAddrQ[$];
   logic [BW*PB-1:0]  wrDataQ[$];
   logic [ADDR_W-1:0] rowQ[$];
   beat_t             sent[$];

   pixel_stream_receiver dut (
      .output_clk     (output_clk),
      .reset          (reset),
      .arm            (arm),
      .data_in        (data_in),
      .data_valid     (data_valid),
      .frame_finished (frame_finished),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .row_done       (row_done),
      .frame_done     (frame_done),
      .frame_error    (frame_error),
      .pixel_sum      (pixel_sum),
      .busy           (busy)
   );

   always #5 output_clk = ~output_clk;

   // Log every observable event one time unit after each rising edge.
   always begin
      @(posedge output_clk);
      #1;
      cycle++;
      if (mem_we === 1'b1) begin
         wrAddrQ.push_back(mem_addr);
         wrDataQ.push_back(mem_wdata);
         lastWeCycle = cycle;
      end
      if (row_done === 1'b1) rowQ.push_back(mem_addr);
      if (frame_done === 1'b1) begin
         doneCount++;
         lastDoneCycle = cycle;
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_mem_we"},      64'(mem_we),      64'd0);
      checkOutput({tag, "_mem_addr"},    64'(mem_addr),    64'd0);
      checkOutput({tag, "_mem_wdata"},   64'(mem_wdata),   64'd0);
      checkOutput({tag, "_row_done"},    64'(row_done),    64'd0);
      checkOutput({tag, "_frame_done"},  64'(frame_done),  64'd0);
      checkOutput({tag, "_frame_error"}, 64'(frame_error), 64'd0);
      checkOutput({tag, "_pixel_sum"},   64'(pixel_sum),   64'd0);
      checkOutput({tag, "_busy"},        64'(busy),        64'd0);
   endtask

   function automatic beat_t makeBeat(input int mode, input int k);
      beat_t b;
      for (int p = 0; p < BW; p++) begin
         case (mode)
            0:       b[p] = PB'(k % 256);
            1:       b[p] = '1;
            default: b[p] = PB'($urandom);
         endcase
      end
      return b;
   endfunction

   // Checksum of the accepted part of the frame, from plain pixel arithmetic.
   function automatic logic [SB-1:0] modelSum(input int accepted);
      longint unsigned total = 0;
      for (int i = 0; i < accepted; i++) begin
         for (int p = 0; p < BW; p++) total += longint'(sent[i][p]);
      end
      return SB'(total % (64'd1 << SB));
   endfunction

   task automatic applyStimulus(input string name, input int nBeats, input int mode,
                                input bit coincide, input bit holdArm);
      int accepted = (nBeats < TOTAL) ? nBeats : TOTAL;
      int expErr   = (nBeats < TOTAL) ? 1 : ((nBeats > TOTAL) ? 2 : 0);
      int doneBase = doneCount;
      int badWr = 0;
      int badRow = 0;
      bit found = 0;
      beat_t b;
      wrAddrQ.delete();
      wrDataQ.delete();
      rowQ.delete();
      sent.delete();
      frame_finished = 1'b1;
      arm = 1'b1;
      @(posedge output_clk);
      #1;
      arm = holdArm;
      checkOutput({name, "_start_busy"},      64'(busy),        64'd1);
      checkOutput({name, "_start_sum_clear"}, 64'(pixel_sum),   64'd0);
      checkOutput({name, "_start_err_clear"}, 64'(frame_error), 64'd0);
      checkOutput({name, "_start_no_done"},   64'(frame_done),  64'd0);
      for (int k = 0; k < nBeats; k++) begin
         if (mode == 2 && !coincide) begin
            while ($urandom_range(0, 3) == 0) begin
               data_valid = 1'b0;
               data_in = BW*PB'($urandom);
               @(posedge output_clk);
               #1;
            end
         end
         b = makeBeat(mode, k);
         sent.push_back(b);
         data_in = b;
         data_valid = 1'b1;
         if (coincide && k == nBeats - 3) frame_finished = 1'b0;
         @(posedge output_clk);
         #1;
      end
      data_valid = 1'b0;
      if (!coincide) begin
         repeat (2) begin
            @(posedge output_clk);
            #1;
         end
         frame_finished = 1'b0;
      end
      for (int c = 0; c < 20 && !found; c++) begin
         @(posedge output_clk);
         #2;
         if (frame_done === 1'b1) found = 1;
      end
      checkOutput({name, "_frame_done_seen"}, 64'(found), 64'd1);
      for (int i = 0; i < wrAddrQ.size(); i++) begin
         if (wrAddrQ[i] !== ADDR_W'(i) || i >= sent.size() || wrDataQ[i] !== sent[i]) badWr++;
      end
      for (int i = 0; i < rowQ.size(); i++) begin
         if (rowQ[i] !== ADDR_W'(BPR * (i + 1) - 1)) badRow++;
      end
      checkOutput({name, "_write_count"},   64'(wrAddrQ.size()),        64'(accepted));
      checkOutput({name, "_write_content"}, 64'(badWr),                 64'd0);
      checkOutput({name, "_row_count"},     64'(rowQ.size()),           64'(accepted / BPR));
      checkOutput({name, "_row_addrs"},     64'(badRow),                64'd0);
      checkOutput({name, "_last_addr"},     64'(mem_addr),              64'(accepted - 1));
      checkOutput({name, "_frame_error"},   64'(frame_error),           64'(expErr));
      checkOutput({name, "_pixel_sum"},     64'(pixel_sum),             64'(modelSum(accepted)));
      checkOutput({name, "_busy_idle"},     64'(busy),                  64'd0);
      checkOutput({name, "_done_pulses"},   64'(doneCount - doneBase),  64'd1);
      if (coincide) begin
         checkOutput({name, "_done_latency"}, 64'(lastDoneCycle - lastWeCycle), 64'd1);
      end
   endtask

   initial begin
      int doneBase;
      frame_finished = 1'b1;
      repeat (3) @(posedge output_clk);
      #1;
      checkAllZero("reset");
      reset = 1'b1;

      data_valid = 1'b1;
      repeat (5) begin
         data_in = BW*PB'($urandom);
         @(posedge output_clk);
         #1;
      end
      data_valid = 1'b0;
      checkOutput("idle_ignores_valid", 64'(wrAddrQ.size()), 64'd0);
      checkOutput("idle_not_busy",      64'(busy),           64'd0);

      applyStimulus("full_ramp", TOTAL,     0, 1'b0, 1'b0);
      applyStimulus("short",     100,       0, 1'b0, 1'b0);
      applyStimulus("overrun",   TOTAL + 3, 2, 1'b0, 1'b0);
      applyStimulus("coincide",  TOTAL,     2, 1'b1, 1'b0);
      applyStimulus("b2b_first", TOTAL,     1, 1'b0, 1'b1);
      applyStimulus("b2b_second", TOTAL,    1, 1'b0, 1'b1);
      arm = 1'b0;

      @(posedge output_clk);
      #1;
      frame_finished = 1'b1;
      arm = 1'b1;
      @(posedge output_clk);
      #1;
      arm = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         data_in = makeBeat(2, k);
         data_valid = 1'b1;
         @(posedge output_clk);
         #1;
      end
      doneBase = doneCount;
      reset = 1'b0;
      @(posedge output_clk);
      #1;
      checkAllZero("abort");
      reset = 1'b1;
      data_valid = 1'b0;
      repeat (5) begin
         @(posedge output_clk);
         #1;
      end
      checkOutput("abort_no_done", 64'(doneCount - doneBase), 64'd0);
      checkOutput("abort_idle",    64'(busy),                 64'd0);

      applyStimulus("after_abort", TOTAL, 2, 1'b0, 1'b0);
      checkOutput("total_frame_done", 64'(doneCount), 64'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
